multicycle_main_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Is the producer of the 2-bit ALU-operation code consumed by the ALU control decoder, and receives that decoder's jr flag back.
- Sits between the instruction register (opcode) and the datapath muxes, the register-file write enable and the memory strobes.

---
 rtl/multicycle_main_control_if.sv | 37 +++
 rtl/multicycle_main_control.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multicycle main FSM (master) and the datapath (slave).
interface multicycle_main_control_if;
    logic [5:0] opcode;
    logic       jr;
    logic       mem_ready;
    logic [1:0] alusignal;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       pcwritecond;
    logic       branch_ne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
    logic       mem_err;
    logic [3:0] state_out;

    modport master (
        input  opcode, jr, mem_ready,
        output alusignal, alusrca, alusrcb, pcsource, pcwrite, pcwritecond, branch_ne,
               iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, illegal,
               mem_err, state_out
    );

    modport slave (
        output opcode, jr, mem_ready,
        input  alusignal, alusrca, alusrcb, pcsource, pcwrite, pcwritecond, branch_ne,
               iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, illegal,
               mem_err, state_out
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath, with memory-wait timeout.
// Optional ADDI support (IEXEC/IWB states) is enabled by defining ADDI_IMM_EN.
module multicycle_main_control #(
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [5:0]  OP_RTYPE = 6'd0,
    parameter logic [5:0]  OP_LW    = 6'd35,
    parameter logic [5:0]  OP_SW    = 6'd43,
    parameter logic [5:0]  OP_BEQ   = 6'd4,
    parameter logic [5:0]  OP_BNE   = 6'd5,
    parameter logic [5:0]  OP_J     = 6'd2
) (
    input logic                       clk,
    input logic                       reset,
    multicycle_main_control_if.master bus
);

`ifdef ADDI_IMM_EN
    localparam logic [5:0] OpAddi = 6'd8;
`endif
    localparam int unsigned CntW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRExec  = 4'd6,
        StRWb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9
`ifdef ADDI_IMM_EN
        , StIExec = 4'd10
        , StIWb   = 4'd11
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic              wait_tmo;

    // Timeout fires on the last allowed idle cycle; mem_ready in that cycle still wins.
    assign wait_tmo = (MAX_WAIT != 0) && !bus.mem_ready &&
                      (wait_cnt_q == CntW'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = '0;
        bus.alusignal   = 2'b00;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.pcsource    = 2'b00;
        bus.pcwrite     = 1'b0;
        bus.pcwritecond = 1'b0;
        bus.branch_ne   = 1'b0;
        bus.iord        = 1'b0;
        bus.memread     = 1'b0;
        bus.memwrite    = 1'b0;
        bus.irwrite     = 1'b0;
        bus.regdst      = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.regwrite    = 1'b0;
        bus.illegal     = 1'b0;
        bus.mem_err     = 1'b0;
        bus.state_out   = state_q;

        case (state_q)
            StFetch: begin
                bus.memread   = 1'b1;
                bus.alusrcb   = 2'b01;
                bus.alusignal = 2'b01;
                if (bus.mem_ready) begin
                    bus.irwrite = 1'b1;
                    bus.pcwrite = 1'b1;
                    state_d     = StDecode;
                end else if (wait_tmo) begin
                    bus.mem_err = 1'b1;
                    state_d     = StFetch;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StDecode: begin
                bus.alusrcb   = 2'b11;
                bus.alusignal = 2'b01;
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
                    state_d = StMemAdr;
                end else if (bus.opcode == OP_RTYPE) begin
                    state_d = StRExec;
                end else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE) begin
                    state_d = StBranch;
                end else if (bus.opcode == OP_J) begin
                    state_d = StJump;
`ifdef ADDI_IMM_EN
                end else if (bus.opcode == OpAddi) begin
                    state_d = StIExec;
`endif
                end else begin
                    bus.illegal = 1'b1;
                    state_d     = StFetch;
                end
            end
            StMemAdr: begin
                bus.alusrca   = 1'b1;
                bus.alusrcb   = 2'b10;
                bus.alusignal = 2'b01;
                state_d       = (bus.opcode == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                bus.iord    = 1'b1;
                bus.memread = 1'b1;
                if (bus.mem_ready) begin
                    state_d = StMemWb;
                end else if (wait_tmo) begin
                    bus.mem_err = 1'b1;
                    state_d     = StFetch;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StMemWb: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = StFetch;
            end
            StMemWr: begin
                bus.iord = 1'b1;
                if (bus.mem_ready) begin
                    bus.memwrite = 1'b1;
                    state_d      = StFetch;
                end else if (wait_tmo) begin
                    bus.mem_err = 1'b1;
                    state_d     = StFetch;
                end else begin
                    bus.memwrite = 1'b1;
                    wait_cnt_d   = wait_cnt_q + CntW'(1);
                end
            end
            StRExec: begin
                bus.alusrca = 1'b1;
                if (bus.jr) begin
                    bus.pcsource = 2'b11;
                    bus.pcwrite  = 1'b1;
                    state_d      = StFetch;
                end else begin
                    state_d = StRWb;
                end
            end
            StRWb: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                state_d      = StFetch;
            end
            StBranch: begin
                bus.alusrca     = 1'b1;
                bus.alusignal   = 2'b11;
                bus.pcsource    = 2'b01;
                bus.pcwritecond = 1'b1;
                bus.branch_ne   = (bus.opcode == OP_BNE);
                state_d         = StFetch;
            end
            StJump: begin
                bus.pcsource = 2'b10;
                bus.pcwrite  = 1'b1;
                state_d      = StFetch;
            end
`ifdef ADDI_IMM_EN
            StIExec: begin
                bus.alusrca   = 1'b1;
                bus.alusrcb   = 2'b10;
                bus.alusignal = 2'b01;
                state_d       = StIWb;
            end
            StIWb: begin
                bus.regwrite = 1'b1;
                state_d      = StFetch;
            end
`endif
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset suppresses every strobe, including the debug state view.
        if (reset) begin
            bus.alusignal   = 2'b00;
            bus.alusrca     = 1'b0;
            bus.alusrcb     = 2'b00;
            bus.pcsource    = 2'b00;
            bus.pcwrite     = 1'b0;
            bus.pcwritecond = 1'b0;
            bus.branch_ne   = 1'b0;
            bus.iord        = 1'b0;
            bus.memread     = 1'b0;
            bus.memwrite    = 1'b0;
            bus.irwrite     = 1'b0;
            bus.regdst      = 1'b0;
            bus.memtoreg    = 1'b0;
            bus.regwrite    = 1'b0;
            bus.illegal     = 1'b0;
            bus.mem_err     = 1'b0;
            bus.state_out   = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: an instruction-level model expands each
// randomized instruction into per-cycle expectations that a negedge monitor checks.
module tb_multicycle_main_control;
    localparam int MW = 4;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
    localparam int S_MEMWR = 5, S_REXEC = 6, S_RWB = 7, S_BRANCH = 8, S_JUMP = 9;
    localparam int S_IEXEC = 10, S_IWB = 11;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] alusignal;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       pcwritecond;
        logic       branch_ne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
        logic       mem_err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    multicycle_main_control_if bus ();

    multicycle_main_control #(.MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    logic [5:0] cur_op;
    bit   cur_jr;
    int   cyc_idx;
    int   abort_at;
    bit   aborted;

    function automatic bit is_legal(input logic [5:0] op);
`ifdef ADDI_IMM_EN
        if (op == 6'd8) return 1'b1;
`endif
        return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd5 ||
               op == 6'd2;
    endfunction

    function automatic exp_t expect_of(input int st, input bit rdy, input bit tmo);
        exp_t e = '0;
        e.st = 4'(st);
        case (st)
            S_FETCH: begin
                e.memread = 1; e.alusrcb = 2'b01; e.alusignal = 2'b01;
                e.irwrite = rdy; e.pcwrite = rdy; e.mem_err = tmo;
            end
            S_DECODE: begin
                e.alusrcb = 2'b11; e.alusignal = 2'b01; e.illegal = !is_legal(cur_op);
            end
            S_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alusignal = 2'b01; end
            S_MEMRD:  begin e.iord = 1; e.memread = 1; e.mem_err = tmo; end
            S_MEMWB:  begin e.memtoreg = 1; e.regwrite = 1; end
            S_MEMWR:  begin e.iord = 1; e.memwrite = !tmo; e.mem_err = tmo; end
            S_REXEC: begin
                e.alusrca = 1;
                if (cur_jr) begin e.pcsource = 2'b11; e.pcwrite = 1; end
            end
            S_RWB:    begin e.regdst = 1; e.regwrite = 1; end
            S_BRANCH: begin
                e.alusrca = 1; e.alusignal = 2'b11; e.pcsource = 2'b01; e.pcwritecond = 1;
                e.branch_ne = (cur_op == 6'd5);
            end
            S_JUMP:   begin e.pcsource = 2'b10; e.pcwrite = 1; end
            S_IEXEC:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.alusignal = 2'b01; end
            S_IWB:    begin e.regwrite = 1; end
            default:  ;
        endcase
        return e;
    endfunction

    // One clock of stimulus plus its expectation; a planned reset cycle aborts the rest.
    task automatic cyc(input int st, input bit rdy, input bit tmo);
        if (aborted) return;
        bus.mem_ready = rdy;
        if (cyc_idx == abort_at) begin
            reset = 1'b1;
            sb.push_back('0);
            aborted = 1'b1;
        end else begin
            reset = 1'b0;
            sb.push_back(expect_of(st, rdy, tmo));
        end
        cyc_idx++;
        @(posedge clk);
        #1;
    endtask

    // Memory wait of w idle cycles; returns 0 if the access times out.
    task automatic mem_wait(input int st, input int w, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (i == MW - 1) begin
                cyc(st, 1'b0, 1'b1);
                ok = 1'b0;
                return;
            end
            cyc(st, 1'b0, 1'b0);
        end
        cyc(st, 1'b1, 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] op, input bit jr, input int wf, input int wm,
                             input int abort);
        bit ok;
        cur_op = op; cur_jr = jr; cyc_idx = 0; abort_at = abort; aborted = 1'b0;
        bus.opcode = op;
        bus.jr = jr;
        // Fetch restarts its idle count after every timeout.
        for (int i = 0; i < wf; i++) cyc(S_FETCH, 1'b0, (i % MW) == MW - 1);
        cyc(S_FETCH, 1'b1, 1'b0);
        cyc(S_DECODE, 1'($urandom), 1'b0);
        if (!is_legal(op)) return;
        case (op)
            6'd0: begin
                cyc(S_REXEC, 1'($urandom), 1'b0);
                if (!jr) cyc(S_RWB, 1'($urandom), 1'b0);
            end
            6'd35: begin
                cyc(S_MEMADR, 1'($urandom), 1'b0);
                mem_wait(S_MEMRD, wm, ok);
                if (ok) cyc(S_MEMWB, 1'($urandom), 1'b0);
            end
            6'd43: begin
                cyc(S_MEMADR, 1'($urandom), 1'b0);
                mem_wait(S_MEMWR, wm, ok);
            end
            6'd4, 6'd5: cyc(S_BRANCH, 1'($urandom), 1'b0);
            6'd2: cyc(S_JUMP, 1'($urandom), 1'b0);
            default: begin
                cyc(S_IEXEC, 1'($urandom), 1'b0);
                cyc(S_IWB, 1'($urandom), 1'b0);
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t exp_v;
            exp_t act;
            exp_v = sb.pop_front();
            act = '{bus.state_out, bus.alusignal, bus.alusrca, bus.alusrcb, bus.pcsource,
                    bus.pcwrite, bus.pcwritecond, bus.branch_ne, bus.iord, bus.memread,
                    bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
                    bus.illegal, bus.mem_err};
            n_tests++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL outputs t=%0t state got %0d want %0d: got %h want %h",
                         $time, act.st, exp_v.st, act, exp_v);
            end
        end
    end

    initial begin
        logic [5:0] ops [8];
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8, 6'd0};
        bus.opcode = 6'd0; bus.jr = 1'b0; bus.mem_ready = 1'b0;
        cur_op = 6'd0; cur_jr = 1'b0; aborted = 1'b0; abort_at = -1; cyc_idx = 0;
        @(posedge clk);
        #1;
        // Two reset cycles: all outputs zero.
        for (int i = 0; i < 2; i++) begin
            reset = 1'b1;
            bus.mem_ready = 1'($urandom);
            sb.push_back('0);
            @(posedge clk);
            #1;
        end
        run_instr(6'd0, 1'b0, 0, 0, -1);
        run_instr(6'd35, 1'b0, 0, 3, -1);
        run_instr(6'd5, 1'b0, 0, 0, -1);
        run_instr(6'd4, 1'b0, 1, 0, -1);
        run_instr(6'd0, 1'b1, 0, 0, -1);
        run_instr(6'd43, 1'b0, 2, 2, -1);
        run_instr(6'd2, 1'b0, 0, 0, -1);
        run_instr(6'd2, 1'b0, 4, 0, -1);
        run_instr(6'd35, 1'b0, 0, 5, -1);
        run_instr(6'd43, 1'b0, 0, 4, -1);
        run_instr(6'd8, 1'b0, 0, 0, -1);
        run_instr(6'd63, 1'b0, 0, 0, -1);
        run_instr(6'd35, 1'b0, 0, 2, 3);
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            int wf, wm, ab;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            wf = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 2);
            wm = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 3);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(op, 1'($urandom), wf, wm, ab);
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
